vp_key_event_queue: RTL and testbench
=====================================

// Module: vp_key_event_queue
// PURPOSE
//  Merges PS/2 key events and per-pad numeric keypad bits into one ordered
//  stream of {ascii, released} events. The stream is buffered in a FIFO and
//  presented through a paced valid/ready port to the vp_keymap scanner.
//  Supersedes the single-register ascii latch. Simultaneous or fast key
//  activity no longer loses events or leaves keys stuck.
// PARAMETERS
//  NUM_PADS   2   number of gamepads contributing keypad bits (1..4)
//  PAD_KEYS   10  keypad bits per pad (1..10); bit k -> "1".."9","0"
//  DEPTH      8   FIFO entries, power of 2 (2..64)
//  GAP_CYCLES 0   idle clk_i cycles forced between consecutive events (0..65535)
// PORTS
//  clk_i          in   1                  system clock
//  res_n_i        in   1                  async reset, active low
//  ps2_key_i      in   11                 [10] toggle, [9] pressed, [8] ext, [7:0] scancode
//  pad_keys_i     in   NUM_PADS*PAD_KEYS  pad p bits [p*PAD_KEYS +: PAD_KEYS], 1 = held
//  ev_valid_o     out  1                  event present
//  ev_ready_i     in   1                  consumer accepts event
//  ev_ascii_o     out  8                  event character
//  ev_released_o  out  1                  1 = key release, 0 = key press
//  level_o        out  clog2(DEPTH)+1     FIFO occupancy
//  overflow_o     out  1                  sticky: a PS/2 event was dropped
// BEHAVIOUR
//  Reset (async, res_n_i=0): all outputs 0, FIFO empty, FSM IDLE,
//   pad reported-vector 0, ps2 primed flag 0.
//  PS/2 path
//   - First cycle after reset: latches ps2_key_i[10], no event.
//   - Afterwards a toggle change = one event. released = ~ps2_key_i[9].
//   - Extended bit is ignored.
//   - Map: digits, a-z, space, + - * / =, 5A->0x0A, 66->0x08,
//     1F->0x11, 27->0x12.
//   - Unmapped scancode -> no event (never enqueues 0x00).
//  Pad path
//   - cur[k] = OR over pads of bit k.
//   - An event exists when cur[k] != reported[k]; lowest k wins.
//   - Event = {ascii(k), released=~cur[k]}; reported[k] <= cur[k] when
//     the event is written.
//   - A press+release both occurring while the event is waiting produces
//     no event. This is intended.
//  Write arbitration: max one FIFO write per cycle.
//   - PS/2 event has priority; a pad event waits (stays pending, lossless).
//   - FIFO full: PS/2 event dropped, overflow_o<=1; pad event not written
//     (remains pending).
//   - Write and read in same cycle while full: read frees the slot first;
//     the write succeeds.
//  Output FSM (states IDLE -> PRESENT -> GAP -> IDLE)
//   - IDLE: FIFO non-empty -> load head into output regs, ev_valid_o=1,
//     go to PRESENT.
//   - PRESENT: hold outputs stable until ev_valid_o&ev_ready_i. Then pop,
//     ev_valid_o=0, go to GAP (or IDLE when GAP_CYCLES=0).
//   - GAP: count GAP_CYCLES cycles, then IDLE.
//  Latency: toggle change sampled at edge N -> FIFO write at N+1 ->
//   ev_valid_o=1 after edge N+2 (FIFO empty, FSM IDLE).
//  Pointers: log2(DEPTH) bits, wrap modulo DEPTH.
//   level_o = writes - reads, never exceeds DEPTH.
//  Reset mid-operation: queued and presented events are discarded. Held
//   pad keys re-report as presses after reset.
// TESTING
//  1 Toggle ps2 with 9'h016 pressed, ready=1 -> ev_valid at +2, ascii
//    "1", released 0, one cycle wide.
//  2 pad0 bit2 and pad1 bit5 rise same cycle -> events "3" then "6",
//    both released=0. Both fall -> "3" rel, "6" rel.
//  3 ready=0, DEPTH=8, 9 mapped ps2 toggles -> level_o=8, overflow_o=1,
//    first 8 events drained in order.
//  4 ps2 event and pad edge same cycle -> ps2 event first, pad event
//    next, none lost.
//  5 GAP_CYCLES=3, 2 queued, ready=1 -> valid pulses separated by exactly
//    3 low cycles.
//  6 Unmapped scancode 9'h0FF toggled -> no event. Reset asserted while
//    valid=1 -> valid=0 at once, level 0.

Source files
------------

// File: rtl/vp_key_event_queue.sv
// ---------------------------------------------------------------------------
// vp_key_event_queue
//
// Merges PS/2 key events and per-pad numeric keypad bits into one ordered
// stream of {ascii, released} events. The events are buffered in a FIFO and
// handed to the keymap scanner through a paced valid/ready port.
//
// Ports
//   clk_i          system clock
//   res_n_i        asynchronous reset, active low
//   ps2_key_i      [10] toggle, [9] pressed, [8] extended (ignored), [7:0] code
//   pad_keys_i     pad p keypad bits at [p*PAD_KEYS +: PAD_KEYS], 1 = held
//   ev_valid_o     event present on ev_ascii_o / ev_released_o
//   ev_ready_i     consumer accepts the presented event
//   ev_ascii_o     event character
//   ev_released_o  1 = key release, 0 = key press
//   level_o        FIFO occupancy (includes the entry being presented)
//   overflow_o     sticky, set when a PS/2 event had to be dropped
// ---------------------------------------------------------------------------
module vp_key_event_queue #(
  parameter int NUM_PADS   = 2,
  parameter int PAD_KEYS   = 10,
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                         clk_i,
  input  logic                         res_n_i,
  input  logic [10:0]                  ps2_key_i,
  input  logic [NUM_PADS*PAD_KEYS-1:0] pad_keys_i,
  output logic                         ev_valid_o,
  input  logic                         ev_ready_i,
  output logic [7:0]                   ev_ascii_o,
  output logic                         ev_released_o,
  output logic [$clog2(DEPTH):0]       level_o,
  output logic                         overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } state_e;

  // Scancode (set 2) to character. Bit 8 of the result flags a mapped code.
  function automatic logic [8:0] ps2_map(input logic [7:0] code);
    logic [8:0] r;
    r = 9'h000;
    case (code)
      8'h45: r = {1'b1, 8'h30};  // 0
      8'h16: r = {1'b1, 8'h31};  // 1
      8'h1E: r = {1'b1, 8'h32};  // 2
      8'h26: r = {1'b1, 8'h33};  // 3
      8'h25: r = {1'b1, 8'h34};  // 4
      8'h2E: r = {1'b1, 8'h35};  // 5
      8'h36: r = {1'b1, 8'h36};  // 6
      8'h3D: r = {1'b1, 8'h37};  // 7
      8'h3E: r = {1'b1, 8'h38};  // 8
      8'h46: r = {1'b1, 8'h39};  // 9
      8'h1C: r = {1'b1, 8'h61};  // a
      8'h32: r = {1'b1, 8'h62};  // b
      8'h21: r = {1'b1, 8'h63};  // c
      8'h23: r = {1'b1, 8'h64};  // d
      8'h24: r = {1'b1, 8'h65};  // e
      8'h2B: r = {1'b1, 8'h66};  // f
      8'h34: r = {1'b1, 8'h67};  // g
      8'h33: r = {1'b1, 8'h68};  // h
      8'h43: r = {1'b1, 8'h69};  // i
      8'h3B: r = {1'b1, 8'h6A};  // j
      8'h42: r = {1'b1, 8'h6B};  // k
      8'h4B: r = {1'b1, 8'h6C};  // l
      8'h3A: r = {1'b1, 8'h6D};  // m
      8'h31: r = {1'b1, 8'h6E};  // n
      8'h44: r = {1'b1, 8'h6F};  // o
      8'h4D: r = {1'b1, 8'h70};  // p
      8'h15: r = {1'b1, 8'h71};  // q
      8'h2D: r = {1'b1, 8'h72};  // r
      8'h1B: r = {1'b1, 8'h73};  // s
      8'h2C: r = {1'b1, 8'h74};  // t
      8'h3C: r = {1'b1, 8'h75};  // u
      8'h2A: r = {1'b1, 8'h76};  // v
      8'h1D: r = {1'b1, 8'h77};  // w
      8'h22: r = {1'b1, 8'h78};  // x
      8'h35: r = {1'b1, 8'h79};  // y
      8'h1A: r = {1'b1, 8'h7A};  // z
      8'h29: r = {1'b1, 8'h20};  // space
      8'h79: r = {1'b1, 8'h2B};  // + (keypad)
      8'h4E: r = {1'b1, 8'h2D};  // -
      8'h7B: r = {1'b1, 8'h2D};  // - (keypad)
      8'h7C: r = {1'b1, 8'h2A};  // * (keypad)
      8'h4A: r = {1'b1, 8'h2F};  // / (main and keypad share the code)
      8'h55: r = {1'b1, 8'h3D};  // =
      8'h5A: r = {1'b1, 8'h0A};  // enter
      8'h66: r = {1'b1, 8'h08};  // backspace
      8'h1F: r = {1'b1, 8'h11};  // left GUI
      8'h27: r = {1'b1, 8'h12};  // right GUI
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // PS/2 input stage
  // -------------------------------------------------------------------------
  logic       ps2_tog_q;
  logic       ps2_tog_prev_q;
  logic       ps2_pressed_q;
  logic [7:0] ps2_code_q;
  logic       ps2_primed_q;
  logic       ps2_ext_unused;
  logic [8:0] ps2_lookup;
  logic       ps2_ev;

  assign ps2_ext_unused = ps2_key_i[8];

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      ps2_tog_q      <= 1'b0;
      ps2_tog_prev_q <= 1'b0;
      ps2_pressed_q  <= 1'b0;
      ps2_code_q     <= 8'h00;
      ps2_primed_q   <= 1'b0;
    end else begin
      ps2_tog_q     <= ps2_key_i[10];
      ps2_pressed_q <= ps2_key_i[9];
      ps2_code_q    <= ps2_key_i[7:0];
      ps2_primed_q  <= 1'b1;
      // On the first edge after reset both copies take the live toggle, so
      // whatever level the keyboard side holds is not mistaken for an event.
      ps2_tog_prev_q <= ps2_primed_q ? ps2_tog_q : ps2_key_i[10];
    end
  end

  assign ps2_lookup = ps2_map(ps2_code_q);
  assign ps2_ev     = ps2_primed_q && (ps2_tog_q != ps2_tog_prev_q) && ps2_lookup[8];

  // -------------------------------------------------------------------------
  // Pad input stage: OR each keypad bit across all pads
  // -------------------------------------------------------------------------
  logic [NUM_PADS-1:0] pad_by_key [PAD_KEYS];
  logic [PAD_KEYS-1:0] pad_or;
  logic [PAD_KEYS-1:0] pad_cur_q;
  logic [PAD_KEYS-1:0] pad_rep_q;
  logic [PAD_KEYS-1:0] pad_sel;
  logic                pad_pend;
  logic [7:0]          pad_ascii;
  logic                pad_rel;
  logic                pad_take;

  for (genvar gi = 0; gi < PAD_KEYS; gi++) begin : g_key
    for (genvar gp = 0; gp < NUM_PADS; gp++) begin : g_pad
      assign pad_by_key[gi][gp] = pad_keys_i[gp*PAD_KEYS + gi];
    end
    assign pad_or[gi] = |pad_by_key[gi];
  end

  // Scan downwards so the lowest differing key ends up selected.
  always_comb begin
    pad_pend  = 1'b0;
    pad_sel   = '0;
    pad_ascii = 8'h00;
    pad_rel   = 1'b0;
    for (int k = PAD_KEYS - 1; k >= 0; k--) begin
      if (pad_cur_q[k] != pad_rep_q[k]) begin
        pad_pend   = 1'b1;
        pad_sel    = '0;
        pad_sel[k] = 1'b1;
        pad_ascii  = (k == 9) ? 8'h30 : 8'(49 + k);
        pad_rel    = ~pad_cur_q[k];
      end
    end
  end

  // The reported vector only advances when its event actually enters the
  // FIFO, so a pad change can wait behind PS/2 traffic or a full FIFO
  // without being lost.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      pad_cur_q <= '0;
      pad_rep_q <= '0;
    end else begin
      pad_cur_q <= pad_or;
      if (pad_take) begin
        pad_rep_q <= (pad_rep_q & ~pad_sel) | (pad_cur_q & pad_sel);
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO and write arbitration
  // -------------------------------------------------------------------------
  logic [8:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] count_q;
  logic          overflow_q;
  logic          fifo_full;
  logic          fifo_nonempty;
  logic          pop;
  logic          wr_room;
  logic          wr_en;
  logic [8:0]    wr_data;
  logic          ovf_set;

  state_e        state_q, state_d;

  assign fifo_full     = (count_q == LW'(DEPTH));
  assign fifo_nonempty = (count_q != '0);
  // An accepted event frees its slot in the same cycle a write lands.
  assign pop           = (state_q == ST_PRESENT) && ev_ready_i;
  assign wr_room       = !fifo_full || pop;

  always_comb begin
    wr_en    = 1'b0;
    wr_data  = 9'h000;
    pad_take = 1'b0;
    ovf_set  = 1'b0;
    if (ps2_ev) begin
      if (wr_room) begin
        wr_en   = 1'b1;
        wr_data = {ps2_lookup[7:0], ~ps2_pressed_q};
      end else begin
        ovf_set = 1'b1;
      end
    end else if (pad_pend && wr_room) begin
      wr_en    = 1'b1;
      wr_data  = {pad_ascii, pad_rel};
      pad_take = 1'b1;
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (wr_en && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!wr_en && pop) begin
        count_q <= count_q - 1'b1;
      end
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output FSM
  // -------------------------------------------------------------------------
  logic        valid_q, valid_d;
  logic [7:0]  ascii_q, ascii_d;
  logic        rel_q, rel_d;
  logic [15:0] gap_q, gap_d;
  logic [8:0]  head;

  assign head = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      ascii_q <= 8'h00;
      rel_q   <= 1'b0;
      gap_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ascii_q <= ascii_d;
      rel_q   <= rel_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ascii_d = ascii_q;
    rel_d   = rel_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty) begin
          valid_d = 1'b1;
          ascii_d = head[8:1];
          rel_d   = head[0];
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (ev_ready_i) begin
          valid_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gap_d   = 16'(GAP_CYCLES - 1);
          end
        end
      end
      ST_GAP: begin
        // The last gap cycle also does the IDLE look-ahead, so the low time
        // between two events is exactly GAP_CYCLES cycles.
        if (gap_q == 16'd0) begin
          if (fifo_nonempty) begin
            valid_d = 1'b1;
            ascii_d = head[8:1];
            rel_d   = head[0];
            state_d = ST_PRESENT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign ev_valid_o    = valid_q;
  assign ev_ascii_o    = ascii_q;
  assign ev_released_o = rel_q;
  assign level_o       = count_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_vp_key_event_queue.sv
// ---------------------------------------------------------------------------
// tb_vp_key_event_queue
//
// Directed bench for vp_key_event_queue. Two instances share the PS/2 and pad
// inputs: dut (GAP_CYCLES=0) and dut_gap (GAP_CYCLES=3) with its own ready.
// Each scenario task drives stimulus and compares against hand-computed
// values; one summary line is printed at the end.
// ---------------------------------------------------------------------------
module tb_vp_key_event_queue;

  logic        clk = 1'b0;
  logic        res_n;
  logic [10:0] ps2_key;
  logic [19:0] pad_keys;
  logic        ready, ready_g;
  logic        valid, rel, ovf;
  logic        valid_g, rel_g, ovf_g;
  logic [7:0]  ascii, ascii_g;
  logic [3:0]  level, level_g;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic tog   = 1'b0;

  always #5 clk = ~clk;

  vp_key_event_queue #(.NUM_PADS(2), .PAD_KEYS(10), .DEPTH(8), .GAP_CYCLES(0)) dut (
    .clk_i(clk), .res_n_i(res_n), .ps2_key_i(ps2_key), .pad_keys_i(pad_keys),
    .ev_valid_o(valid), .ev_ready_i(ready), .ev_ascii_o(ascii),
    .ev_released_o(rel), .level_o(level), .overflow_o(ovf)
  );

  vp_key_event_queue #(.NUM_PADS(2), .PAD_KEYS(10), .DEPTH(8), .GAP_CYCLES(3)) dut_gap (
    .clk_i(clk), .res_n_i(res_n), .ps2_key_i(ps2_key), .pad_keys_i(pad_keys),
    .ev_valid_o(valid_g), .ev_ready_i(ready_g), .ev_ascii_o(ascii_g),
    .ev_released_o(rel_g), .level_o(level_g), .overflow_o(ovf_g)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ps2(input logic [7:0] code, input logic pressed);
    tog     = ~tog;
    ps2_key = {tog, pressed, 1'b0, code};
    tick();
  endtask

  task automatic do_reset();
    res_n    = 1'b0;
    ready    = 1'b0;
    ready_g  = 1'b0;
    pad_keys = '0;
    tick();
    tick();
    res_n = 1'b1;
    tick();
    tick();
  endtask

  // Waits (bounded) for the next presented event on dut and returns it.
  task automatic get_event(output logic [7:0] a, output logic r, output bit ok);
    ok = 1'b0;
    a  = 8'h00;
    r  = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (valid === 1'b1) begin
        ok = 1'b1;
        a  = ascii;
        r  = rel;
      end
    end
  endtask

  task automatic test_reset();
    ps2_key  = '0;
    pad_keys = '0;
    ready    = 1'b0;
    ready_g  = 1'b0;
    res_n    = 1'b0;
    tick();
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (ascii !== 8'h00) begin n_bad++; $display("FAIL reset_ascii: got %h want 00", ascii); end
    n_cmp++; if (rel !== 1'b0) begin n_bad++; $display("FAIL reset_rel: got %b want 0", rel); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if (valid_g !== 1'b0) begin n_bad++; $display("FAIL reset_valid_g: got %b want 0", valid_g); end
    res_n = 1'b1;
    tick();
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL prime_no_event: got valid %b want 0", valid); end
  endtask

  task automatic test_single();
    logic [7:0] a; logic r; bit ok;
    do_reset();
    ready   = 1'b1;
    tog     = ~tog;
    ps2_key = {tog, 1'b1, 9'h016};
    tick();  // edge N samples the toggle
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL t1_valid_n: got %b want 0", valid); end
    tick();  // N+1 writes the FIFO
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL t1_valid_n1: got %b want 0", valid); end
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL t1_level_n1: got %0d want 1", level); end
    tick();  // N+2 presents
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL t1_valid_n2: got %b want 1", valid); end
    n_cmp++; if (ascii !== 8'h31) begin n_bad++; $display("FAIL t1_ascii: got %h want 31", ascii); end
    n_cmp++; if (rel !== 1'b0) begin n_bad++; $display("FAIL t1_rel: got %b want 0", rel); end
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL t1_width: got %b want 0", valid); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL t1_level_pop: got %0d want 0", level); end
    send_ps2(8'h16, 1'b0);
    get_event(a, r, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL t1_rel_seen: got %b want 1", ok); end
    n_cmp++; if ({a, r} !== {8'h31, 1'b1}) begin n_bad++; $display("FAIL t1_rel_event: got %h/%b want 31/1", a, r); end
  endtask

  task automatic test_pad_pair();
    logic [7:0] a; logic r; bit ok;
    logic [8:0] exp [4];
    exp[0] = {8'h33, 1'b0}; exp[1] = {8'h36, 1'b0};
    exp[2] = {8'h33, 1'b1}; exp[3] = {8'h36, 1'b1};
    do_reset();
    ready        = 1'b1;
    pad_keys[2]  = 1'b1;   // pad0 bit2 -> "3"
    pad_keys[15] = 1'b1;   // pad1 bit5 -> "6"
    for (int i = 0; i < 4; i++) begin
      if (i == 2) pad_keys = '0;
      get_event(a, r, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL t2_seen%0d: got %b want 1", i, ok); end
      n_cmp++; if ({a, r} !== exp[i]) begin n_bad++; $display("FAIL t2_event%0d: got %h/%b want %h/%b", i, a, r, exp[i][8:1], exp[i][0]); end
    end
    tick(); tick(); tick(); tick();
    n_cmp++; if (level !== 4'd0 || valid !== 1'b0) begin n_bad++; $display("FAIL t2_idle: got level %0d valid %b want 0/0", level, valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] a; logic r; bit ok;
    logic [7:0] codes [9];
    codes[0] = 8'h16; codes[1] = 8'h1E; codes[2] = 8'h26; codes[3] = 8'h25; codes[4] = 8'h2E;
    codes[5] = 8'h36; codes[6] = 8'h3D; codes[7] = 8'h3E; codes[8] = 8'h46;
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 9; i++) send_ps2(codes[i], 1'b1);
    tick(); tick(); tick();
    n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL t3_level: got %0d want 8", level); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL t3_ovf: got %b want 1", ovf); end
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL t3_valid: got %b want 1", valid); end
    n_cmp++; if (ascii !== 8'h31) begin n_bad++; $display("FAIL t3_head: got %h want 31", ascii); end
    ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      get_event(a, r, ok);
      n_cmp++; if (ok !== 1'b1 || a !== 8'(8'h31 + i)) begin n_bad++; $display("FAIL t3_drain%0d: got %h (seen %b) want %h", i, a, ok, 8'(8'h31 + i)); end
    end
    tick(); tick(); tick(); tick();
    n_cmp++; if (level !== 4'd0 || valid !== 1'b0) begin n_bad++; $display("FAIL t3_empty: got level %0d valid %b want 0/0", level, valid); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL t3_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_priority();
    logic [7:0] a; logic r; bit ok;
    do_reset();
    ready       = 1'b1;
    tog         = ~tog;
    ps2_key     = {tog, 1'b1, 9'h01C};   // "a"
    pad_keys[0] = 1'b1;                  // "1"
    get_event(a, r, ok);
    n_cmp++; if (ok !== 1'b1 || {a, r} !== {8'h61, 1'b0}) begin n_bad++; $display("FAIL t4_first: got %h/%b (seen %b) want 61/0", a, r, ok); end
    get_event(a, r, ok);
    n_cmp++; if (ok !== 1'b1 || {a, r} !== {8'h31, 1'b0}) begin n_bad++; $display("FAIL t4_second: got %h/%b (seen %b) want 31/0", a, r, ok); end
    pad_keys = '0;
    get_event(a, r, ok);
    n_cmp++; if (ok !== 1'b1 || {a, r} !== {8'h31, 1'b1}) begin n_bad++; $display("FAIL t4_release: got %h/%b (seen %b) want 31/1", a, r, ok); end
  endtask

  task automatic test_gap();
    int highs, first_hi, second_hi;
    logic [7:0] a2;
    do_reset();
    ready_g = 1'b0;
    send_ps2(8'h1E, 1'b1);   // "2"
    send_ps2(8'h26, 1'b1);   // "3"
    tick(); tick(); tick(); tick();
    n_cmp++; if (valid_g !== 1'b1 || ascii_g !== 8'h32) begin n_bad++; $display("FAIL t5_head: got %b/%h want 1/32", valid_g, ascii_g); end
    ready_g   = 1'b1;
    highs     = 0;
    first_hi  = -1;
    second_hi = -1;
    a2        = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      if (valid_g === 1'b1) begin
        highs++;
        if (highs == 1) first_hi = i;
        if (highs == 2) begin second_hi = i; a2 = ascii_g; end
      end
    end
    n_cmp++; if (highs !== 2) begin n_bad++; $display("FAIL t5_pulses: got %0d want 2", highs); end
    n_cmp++; if (second_hi - first_hi - 1 !== 3) begin n_bad++; $display("FAIL t5_gap: got %0d want 3", second_hi - first_hi - 1); end
    n_cmp++; if (a2 !== 8'h33) begin n_bad++; $display("FAIL t5_second: got %h want 33", a2); end
    n_cmp++; if (level_g !== 4'd0) begin n_bad++; $display("FAIL t5_level: got %0d want 0", level_g); end
  endtask

  task automatic test_unmapped_reset();
    logic [7:0] a; logic r; bit ok;
    bit saw;
    do_reset();
    ready = 1'b0;
    send_ps2(8'hFF, 1'b1);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid === 1'b1) saw = 1'b1;
    end
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL t6_unmapped: got event %b want 0", saw); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL t6_unmapped_lvl: got %0d want 0", level); end
    send_ps2(8'h45, 1'b1);   // "0"
    send_ps2(8'h16, 1'b1);   // "1", stays queued behind it
    tick(); tick();
    n_cmp++; if (valid !== 1'b1 || ascii !== 8'h30) begin n_bad++; $display("FAIL t6_pre: got %b/%h want 1/30", valid, ascii); end
    #3;
    res_n = 1'b0;
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL t6_rst_valid: got %b want 0", valid); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL t6_rst_level: got %0d want 0", level); end
    tick();
    res_n = 1'b1;
    // A pad key held across a reset is reported again as a press.
    ready       = 1'b1;
    pad_keys[4] = 1'b1;      // "5"
    get_event(a, r, ok);
    n_cmp++; if (ok !== 1'b1 || {a, r} !== {8'h35, 1'b0}) begin n_bad++; $display("FAIL t6_pad: got %h/%b (seen %b) want 35/0", a, r, ok); end
    res_n = 1'b0;
    tick();
    res_n = 1'b1;
    get_event(a, r, ok);
    n_cmp++; if (ok !== 1'b1 || {a, r} !== {8'h35, 1'b0}) begin n_bad++; $display("FAIL t6_repress: got %h/%b (seen %b) want 35/0", a, r, ok); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_pad_pair();
    test_overflow();
    test_priority();
    test_gap();
    test_unmapped_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
